// File: rtl/flash_read_arbiter_if.sv
// Signal bundle between flash_read_arbiter, its two burst requesters and the flash byte reader.
// master = the arbiter; slave = everything around it (requesters and reader).
interface flash_read_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 8
);
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [LEN_W-1:0]  len0, len1;
  logic              gnt0, gnt1;
  logic [7:0]        rdata;
  logic              rvalid0, rvalid1;
  logic              rready0, rready1;
  logic              done0, done1;
  logic              err;
  logic              rd_read;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic [7:0]        rd_data;

  modport master (
    input  req0, req1, addr0, addr1, len0, len1, rready0, rready1, rd_ready, rd_data,
    output gnt0, gnt1, rdata, rvalid0, rvalid1, done0, done1, err, rd_read, rd_addr
  );

  modport slave (
    output req0, req1, addr0, addr1, len0, len1, rready0, rready1, rd_ready, rd_data,
    input  gnt0, gnt1, rdata, rvalid0, rvalid1, done0, done1, err, rd_read, rd_addr
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Two-port burst-read arbiter/sequencer: one single-byte reader transaction per byte, valid/ready return.
// Build option FLASH_ARB_FIXED_PRIO_EN: req0 always wins a tie (no round-robin pointer).
module flash_read_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  flash_read_arbiter_if.master bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [LEN_W:0]   REM_ONE = (LEN_W + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              g_q, g_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W:0]    remain_q, remain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              any_req;
  logic              pick;
  logic              rready_g;
  logic [LEN_W-1:0]  len_pick;

  assign any_req  = bus.req0 | bus.req1;
  assign rready_g = g_q ? bus.rready1 : bus.rready0;
  assign len_pick = pick ? bus.len1 : bus.len0;

`ifdef FLASH_ARB_FIXED_PRIO_EN
  assign pick = ~bus.req0;
`else
  logic last_q, last_d;

  // On a tie the requester that was not granted last wins.
  assign pick = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && any_req) begin
      last_d = pick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.rd_ready) begin
          state_d = S_HOLD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_DONE;
        end
      end
      S_HOLD:  if (rready_g) state_d = (remain_q == REM_ONE) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Burst datapath: latched at grant, stepped once per accepted byte.
  always_comb begin
    g_d        = g_q;
    gnt_d      = 1'b0;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          g_d        = pick;
          gnt_d      = 1'b1;
          cur_addr_d = pick ? bus.addr1 : bus.addr0;
          remain_d   = (len_pick == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_pick};
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        if (bus.rd_ready) begin
          rdata_d = bus.rd_data;
        end else if (cnt_q == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (rready_g && remain_q != REM_ONE) begin
          cur_addr_d = cur_addr_q + 1'b1;
          remain_d   = remain_q - 1'b1;
        end
      end
      S_DONE:  err_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q        <= 1'b0;
      gnt_q      <= 1'b0;
      cur_addr_q <= '0;
      remain_q   <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      g_q        <= g_d;
      gnt_q      <= gnt_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    bus.gnt0    = gnt_q & ~g_q;
    bus.gnt1    = gnt_q & g_q;
    bus.rd_read = (state_q == S_ISSUE);
    bus.rd_addr = cur_addr_q;
    bus.rvalid0 = (state_q == S_HOLD) & ~g_q;
    bus.rvalid1 = (state_q == S_HOLD) & g_q;
    bus.done0   = (state_q == S_DONE) & ~g_q;
    bus.done1   = (state_q == S_DONE) & g_q;
    bus.rdata   = rdata_q;
    bus.err     = err_q;
  end
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Randomized bench for flash_read_arbiter: behavioural flash/reader model plus burst-level expectations.
`timescale 1ns/1ps
module tb_flash_read_arbiter;
  localparam int ADDR_W  = 24;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_gnt = 1;
  bit   reader_mute = 1'b0;
  bit   stray = 1'b0;
  int   addr_unstable = 0;
  logic [23:0] issued_q[$];

  flash_read_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  flash_read_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Flash contents as a fixed function of the byte address.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [7:0] m;
    m = 8'(a[7:0] * 8'd37);
    return m ^ a[15:8] ^ {a[23:20], a[3:0]} ^ 8'hA5;
  endfunction

  function automatic bit rv(input int p);
    return (p == 0) ? bus.rvalid0 : bus.rvalid1;
  endfunction

  function automatic bit dn(input int p);
    return (p == 0) ? bus.done0 : bus.done1;
  endfunction

  function automatic bit gn(input int p);
    return (p == 0) ? bus.gnt0 : bus.gnt1;
  endfunction

  task automatic set_req(input int p, input bit v, input logic [23:0] a, input logic [7:0] l);
    if (p == 0) begin
      bus.req0 = v; bus.addr0 = a; bus.len0 = l;
    end else begin
      bus.req1 = v; bus.addr1 = a; bus.len1 = l;
    end
  endtask

  task automatic set_rdy(input int p, input bit v);
    if (p == 0) bus.rready0 = v;
    else        bus.rready1 = v;
  endtask

  // Reader model: answers each rd_read after 1..4 cycles with the flash byte.
  initial begin
    bit          pend;
    logic [23:0] pend_addr;
    int          cnt;
    pend = 1'b0;
    pend_addr = '0;
    cnt = 0;
    bus.rd_ready = 1'b0;
    bus.rd_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.rd_ready = 1'b0;
      bus.rd_data  = 8'($urandom);
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        if (bus.rd_addr !== pend_addr) addr_unstable++;
        cnt--;
        if (cnt == 0) begin
          bus.rd_ready = 1'b1;
          bus.rd_data  = mem_byte(pend_addr);
          pend = 1'b0;
        end
      end else if (bus.rd_read && !reader_mute) begin
        pend = 1'b1;
        pend_addr = bus.rd_addr;
        cnt = $urandom_range(1, 4);
        issued_q.push_back(bus.rd_addr);
      end
      if (stray) bus.rd_ready = 1'b1;
    end
  end

  // One complete burst; must be called with the DUT in IDLE.
  task automatic do_burst(input int p, input logic [23:0] a, input logic [7:0] l,
                          input int stall_at, input int stall_cyc, input bit rnd_rdy);
    int n, idx, waited, acc_cyc, stall_left, bad, bad_addr;
    bit got_gnt, got_done, holding, exp_issue, rdy;
    logic [7:0]  held;
    logic [23:0] ea;
    n = (l == 8'd0) ? 256 : int'(l);
    issued_q.delete();
    set_req(p, 1'b1, a, l);
    got_gnt = 1'b0;
    waited = 0;
    while (waited < 100 && !got_gnt) begin
      tick();
      waited++;
      if (gn(p)) got_gnt = 1'b1;
    end
    chk_eq("gnt_seen", 32'(got_gnt), 32'd1);
    if (!got_gnt) begin
      set_req(p, 1'b0, a, l);
      return;
    end
    chk_eq("gnt_lat", 32'(waited), 32'd1);
    chk_eq("gnt_other", 32'(gn(1 - p)), 32'd0);
    chk_eq("gnt_rd_read", 32'(bus.rd_read), 32'd1);
    chk_eq("gnt_rd_addr", 32'(bus.rd_addr), 32'(a));
    last_gnt = p;
    set_req(p, 1'b0, a, l);

    idx = 0; acc_cyc = 0; stall_left = stall_cyc; bad = 0;
    got_done = 1'b0; holding = 1'b0; exp_issue = 1'b0; held = 8'h00;
    for (int t = 0; t < 4000 && !got_done; t++) begin
      tick();
      if (rv(1 - p) || dn(1 - p)) bad++;
      if (holding && (!rv(p) || bus.rdata !== held || bus.rd_read)) bad++;
      if (exp_issue) begin
        ea = a + 24'(idx);
        if (!bus.rd_read || rv(p) || bus.rd_addr !== ea) bad++;
        exp_issue = 1'b0;
      end
      if (dn(p)) begin
        got_done = 1'b1;
        chk_eq("done_err", 32'(bus.err), 32'd0);
        chk_eq("done_lat", 32'(cyc - acc_cyc), 32'd1);
        chk_eq("bytes", 32'(idx), 32'(n));
      end else if (rv(p)) begin
        if (idx == stall_at && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else begin
          rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        set_rdy(p, rdy);
        if (!holding) begin
          ea = a + 24'(idx);
          chk_eq("rdata", 32'(bus.rdata), 32'(mem_byte(ea)));
        end
        if (rdy) begin
          idx++;
          acc_cyc = cyc;
          holding = 1'b0;
          if (idx < n) exp_issue = 1'b1;
        end else begin
          holding = 1'b1;
          held = bus.rdata;
        end
      end else begin
        set_rdy(p, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      end
    end
    chk_eq("done_seen", 32'(got_done), 32'd1);
    set_rdy(p, 1'b0);
    bad_addr = 0;
    foreach (issued_q[i]) if (issued_q[i] !== a + 24'(i)) bad_addr++;
    chk_eq("n_issued", 32'(issued_q.size()), 32'(n));
    chk_eq("issue_addr", 32'(bad_addr), 32'd0);
    chk_eq("protocol", 32'(bad), 32'd0);
    $display("burst p=%0d addr=%06h len=%0d bytes=%0d", p, a, n, idx);
    tick();
  endtask

  // Both requesters ask at once with len 1; checks winner, loser's regrant and gap.
  task automatic tie_test(input logic [23:0] a0, input logic [23:0] a1);
    int w, exp_w, o, done_cyc, g2_cyc;
`ifdef FLASH_ARB_FIXED_PRIO_EN
    exp_w = 0;
`else
    exp_w = (last_gnt == 1) ? 0 : 1;
`endif
    bus.rready0 = 1'b1;
    bus.rready1 = 1'b1;
    set_req(0, 1'b1, a0, 8'd1);
    set_req(1, 1'b1, a1, 8'd1);
    w = -1;
    for (int t = 0; t < 50 && w < 0; t++) begin
      tick();
      if (bus.gnt0) w = 0;
      else if (bus.gnt1) w = 1;
    end
    chk_eq("tie_first", 32'(w), 32'(exp_w));
    if (w < 0) begin
      set_req(0, 1'b0, a0, 8'd1);
      set_req(1, 1'b0, a1, 8'd1);
      return;
    end
    o = 1 - w;
    last_gnt = w;
    set_req(w, 1'b0, (w == 0) ? a0 : a1, 8'd1);
    done_cyc = -1;
    for (int t = 0; t < 50 && done_cyc < 0; t++) begin
      tick();
      if (dn(w)) done_cyc = cyc;
    end
    chk_eq("tie_done1", 32'(done_cyc >= 0), 32'd1);
    g2_cyc = -1;
    for (int t = 0; t < 50 && g2_cyc < 0; t++) begin
      tick();
      if (gn(o)) g2_cyc = cyc;
      else if (gn(w)) g2_cyc = -2;
    end
    chk_eq("tie_second", 32'(g2_cyc >= 0), 32'd1);
    chk_eq("regrant_gap", 32'(g2_cyc - done_cyc), 32'd2);
    last_gnt = o;
    set_req(o, 1'b0, (o == 0) ? a0 : a1, 8'd1);
    done_cyc = -1;
    for (int t = 0; t < 50 && done_cyc < 0; t++) begin
      tick();
      if (dn(o)) done_cyc = cyc;
    end
    chk_eq("tie_done2", 32'(done_cyc >= 0), 32'd1);
    bus.rready0 = 1'b0;
    bus.rready1 = 1'b0;
    $display("tie winner=%0d then=%0d", w, o);
    tick();
  endtask

  initial begin
    int c, done_cyc, rv_seen, p, sa;
    logic [23:0] a;
    logic [7:0]  l;
    rst = 1'b1;
    set_req(0, 1'b0, 24'h0, 8'h0);
    set_req(1, 1'b0, 24'h0, 8'h0);
    bus.rready0 = 1'b0;
    bus.rready1 = 1'b0;
    repeat (3) tick();
    chk_eq("reset_ctl", 32'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                              bus.done0, bus.done1, bus.err, bus.rd_read}), 32'd0);
    chk_eq("reset_rdata", 32'(bus.rdata), 32'd0);
    chk_eq("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
    rst = 1'b0;
    last_gnt = 1;
    tick();

    tie_test(24'h000100, 24'h000200);
    tie_test(24'h000300, 24'h000400);
    do_burst(0, 24'h400000, 8'd3, -1, 0, 1'b0);
    do_burst(1, 24'hFFFFFE, 8'd3, -1, 0, 1'b0);
    do_burst(0, 24'($urandom), 8'd3, 1, 50, 1'b0);
    do_burst(0, 24'($urandom), 8'd0, -1, 0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      p = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? 24'hFFFFF8 + 24'($urandom_range(0, 7)) : 24'($urandom);
      l = 8'($urandom_range(1, 8));
      sa = $urandom_range(0, int'(l) - 1);
      do_burst(p, a, l, sa, $urandom_range(0, 6), 1'b1);
    end
    tie_test(24'($urandom), 24'($urandom));

    // Reader silent: burst must abort with err exactly TIMEOUT+1 cycles after rd_read.
    reader_mute = 1'b1;
    set_req(0, 1'b1, 24'h123456, 8'd2);
    c = -1;
    for (int t = 0; t < 50 && c < 0; t++) begin
      tick();
      if (bus.gnt0 && bus.rd_read) c = cyc;
    end
    chk_eq("to_gnt", 32'(c >= 0), 32'd1);
    set_req(0, 1'b0, 24'h123456, 8'd2);
    last_gnt = 0;
    bus.rready0 = 1'b1;
    rv_seen = 0;
    done_cyc = -1;
    for (int t = 0; t < 200 && done_cyc < 0; t++) begin
      tick();
      if (bus.rvalid0 || bus.rvalid1) rv_seen++;
      if (bus.done0) begin
        done_cyc = cyc;
        chk_eq("to_err", 32'(bus.err), 32'd1);
      end
    end
    chk_eq("to_latency", 32'(done_cyc - c), 32'(TIMEOUT + 1));
    chk_eq("to_no_rvalid", 32'(rv_seen), 32'd0);
    tick();
    chk_eq("err_cleared", 32'(bus.err), 32'd0);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    rv_seen = 0;
    repeat (5) begin
      tick();
      if (bus.rvalid0 || bus.rvalid1 || bus.rd_read) rv_seen++;
    end
    chk_eq("stray_ignored", 32'(rv_seen), 32'd0);
    bus.rready0 = 1'b0;
    reader_mute = 1'b0;
    $display("timeout latency=%0d", done_cyc - c);
    do_burst(1, 24'h00ABCD, 8'd2, -1, 0, 1'b0);

    // Asynchronous reset in the middle of a long burst.
    bus.rready0 = 1'b1;
    set_req(0, 1'b1, 24'h777000, 8'd30);
    c = -1;
    for (int t = 0; t < 50 && c < 0; t++) begin
      tick();
      if (bus.gnt0) c = cyc;
    end
    set_req(0, 1'b0, 24'h777000, 8'd30);
    repeat (12) tick();
    #3 rst = 1'b1;
    #1;
    chk_eq("mid_rst_ctl", 32'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                                bus.done0, bus.done1, bus.err, bus.rd_read}), 32'd0);
    chk_eq("mid_rst_rdata", 32'(bus.rdata), 32'd0);
    chk_eq("mid_rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    bus.rready0 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    last_gnt = 1;
    $display("reset mid-burst at cycle %0d", cyc);
    repeat (6) tick();
    tie_test(24'h001000, 24'h002000);
    do_burst(1, 24'($urandom), 8'd5, 2, 3, 1'b1);

    chk_eq("rd_addr_stable", 32'(addr_unstable), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation did not finish");
  end
endmodule

// File: doc/flash_read_arbiter.md
# flash_read_arbiter

Two-port burst-read arbiter and sequencer in front of the QPI flash byte reader. Each requester posts a start address and byte count. The block grants one requester at a time (round-robin), issues one single-byte reader transaction per byte, and hands each byte back through a valid/ready handshake. It sits between the flash reader and its clients, for example the UART dump path and a second fetch engine.

## Interface
Parameters:
- `ADDR_W`, 24: flash byte address width.
- `LEN_W`, 8: burst length width; a length of 0 means 2^LEN_W bytes.
- `TIMEOUT`, 64: cycles allowed in WAIT for `rd_ready` before the burst is aborted.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, same clock as the reader.
- `rst` in 1: asynchronous, active-high reset.
- `req0` / `req1` in 1: burst request; held high until the matching `gnt`.
- `addr0` / `addr1` in ADDR_W: burst start address; sampled at grant.
- `len0` / `len1` in LEN_W: burst byte count; sampled at grant.
- `gnt0` / `gnt1` out 1: one-cycle grant pulse.
- `rdata` out 8: byte being returned, shared by both requesters.
- `rvalid0` / `rvalid1` out 1: `rdata` valid for that requester; held until accepted.
- `rready0` / `rready1` in 1: requester accepts the byte.
- `done0` / `done1` out 1: one-cycle burst-complete pulse.
- `err` out 1: qualifies `done`; 1 = burst aborted by timeout.
- `rd_read` out 1: one-cycle read strobe to the reader.
- `rd_addr` out ADDR_W: reader address; stable from `rd_read` until `rd_ready`.
- `rd_ready` in 1: reader one-cycle data-valid pulse.
- `rd_data` in 8: reader byte.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: assert `rd_read`.
  - WAIT: wait for `rd_ready`, timeout counter running.
  - HOLD: `rvalid_g` is high.
  - DONE: assert `done_g`.
- Transitions:
  - IDLE: if any `req` is high, go to ISSUE. Latch `g`, `cur_addr` and `remain`; `remain` = 2^LEN_W when `len` is 0. Pulse `gnt_g`.
  - ISSUE: always go to WAIT; clear the timeout counter.
  - WAIT: on `rd_ready`, latch `rdata` from `rd_data` and go to HOLD. If the counter reaches TIMEOUT-1 with no `rd_ready`, set `err`=1 and go to DONE.
  - HOLD: on `rready_g`, go to DONE if `remain`==1. Otherwise increment `cur_addr`, decrement `remain` and go to ISSUE.
  - DONE: go to IDLE; `err` clears on the IDLE entry.
- Arbitration:
  - If only one request is high, that requester is granted.
  - If both are high, the requester that was not granted last wins. The `last` pointer resets to 1, so `req0` wins the first tie.
  - Requests are sampled only in IDLE. Requests outside IDLE are ignored; they are not queued or dropped-and-flagged.
- Address arithmetic: `cur_addr` increments modulo 2^ADDR_W, so 0xFFFFFF is followed by 0x000000.
- `rd_ready` outside WAIT is ignored. This covers a late reader completion after a timeout.
- Reset (any cycle, including mid-burst):
  - All outputs 0: `gnt*`, `rvalid*`, `done*`, `err`, `rd_read`, `rdata`, `rd_addr`.
  - State returns to IDLE and `last` to 1.
  - The reader must be reset by the same `rst`.

## Timing
- Grant: `req` is sampled high at edge k.
  - Cycle k+1: `gnt_g`=1 and `rd_read`=1, with `rd_addr` equal to the start address.
  - Cycle k+2: state is WAIT.
- Byte return: `rd_ready` is sampled at edge m. In cycle m+1, `rvalid_g`=1 and `rdata` holds the byte.
- Accept: `rvalid_g && rready_g` is sampled at edge n.
  - Not the last byte: in cycle n+1, `rd_read`=1 at the next address and `rvalid_g`=0.
  - Last byte: in cycle n+1, `done_g`=1 with `err`=0.
- Next grant: the earliest next `gnt` is 2 cycles after `done`.
- `rready` asserted in the same cycle that `rvalid` rises counts. Overhead per byte, excluding the reader, is 3 cycles.
- Timeout: `done_g`=1 and `err`=1 exactly TIMEOUT+1 cycles after the `rd_read` cycle, with no `rvalid`.

## Configuration
- `FLASH_ARB_FIXED_PRIO_EN`:
  - Defined: `req0` always wins a tie and the `last` pointer is removed.
  - Undefined (default): round-robin as described under Arbitration.

## Test plan
- `req0`, `addr0`=0x400000, `len0`=3, `rready0` tied high, reader returning 0xA1/0xB2/0xC3 → `rd_addr` sequence 0x400000/0x400001/0x400002; `rvalid0` returns A1, B2, C3; one `done0` pulse with `err`=0.
- `req0` and `req1` asserted together from reset, `len`=1 each → `gnt0` first, then `gnt1`. Repeat the tie → `gnt0` again. With `FLASH_ARB_FIXED_PRIO_EN` defined, `gnt0` wins every time.
- `addr1`=0xFFFFFE, `len1`=3 → `rd_addr` sequence 0xFFFFFE, 0xFFFFFF, 0x000000.
- `rready0` held low for 50 cycles on byte 2 → `rvalid0` and `rdata` stable throughout; no `rd_read` issued until accept.
- Reader never answers, TIMEOUT=64 → `done0`=1 and `err`=1 at 65 cycles after `rd_read`; a stray `rd_ready` arriving later produces no `rvalid`.
- `len0`=0 → 256 bytes returned. Separately, `rst` pulsed mid-burst → all outputs 0 asynchronously, and a fresh `req1` is then granted normally.
